// File: rtl/wb_pkg.sv
// Shared types for the regfile writeback arbiter: default widths, the queued
// write request record and the write-source encoding used for debug.
package wb_pkg;

  localparam int ADDR_WIDTH = 5;
  localparam int DATA_WIDTH = 32;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    WB_NONE = 2'd0,
    WB_PIPE = 2'd1,
    WB_MD   = 2'd2
  } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous request FIFO, registered storage with no fall-through: a pushed
// entry becomes visible at the head only after the enqueue edge.
module wb_fifo #(
  parameter type T     = wb_pkg::wb_req_t,
  parameter int  DEPTH = 2
) (
  input  logic                     clock,
  input  logic                     ctrl_resetn,
  input  logic                     push,
  input  T                         push_data,
  input  logic                     pop,
  output T                         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  T              mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  // Guard against overflow/underflow even if the caller misbehaves.
  always_comb begin
    push_ok_s = push && (count_r != FULL_C);
    pop_ok_s  = pop && (count_r != {CW{1'b0}});
  end

  // Storage and pointer/occupancy state; pointers wrap since DEPTH is a power of two.
  always_ff @(posedge clock or negedge ctrl_resetn) begin
    if (!ctrl_resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= T'(0);
      end
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;

endmodule

// File: rtl/writeback_arbiter.sv
// Merges pipeline writeback and buffered multdiv results onto the regfile
// write port; pipeline has priority. Optional busy scoreboard: WB_SCOREBOARD_EN.
module writeback_arbiter #(
  parameter int DATA_WIDTH = wb_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = wb_pkg::ADDR_WIDTH,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                          clock,
  input  logic                          ctrl_resetn,
  input  logic                          pipe_valid,
  input  logic [ADDR_WIDTH-1:0]         pipe_reg,
  input  logic [DATA_WIDTH-1:0]         pipe_data,
  input  logic                          md_valid,
  output logic                          md_ready,
  input  logic [ADDR_WIDTH-1:0]         md_reg,
  input  logic [DATA_WIDTH-1:0]         md_data,
  output logic                          ctrl_writeEnable,
  output logic [ADDR_WIDTH-1:0]         ctrl_writeReg,
  output logic [DATA_WIDTH-1:0]         data_writeReg,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef WB_SCOREBOARD_EN
  ,
  input  logic                          md_issue,
  input  logic [ADDR_WIDTH-1:0]         md_issue_reg,
  output logic [31:0]                   busy
`endif
);

  import wb_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] FULL_C = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] rd;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  logic            ready_en_r;
  logic            we_r;
  logic [ADDR_WIDTH-1:0] wreg_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic            pipe_hit_s;
  logic            push_s;
  logic            pop_s;
  wb_src_e         src_s;
  req_t            push_req_s;
  req_t            head_s;
  logic [CW-1:0]   count_s;

  // Handshake and arbitration; a write to r0 never counts as a write.
  always_comb begin
    pipe_hit_s = pipe_valid && (pipe_reg != {ADDR_WIDTH{1'b0}});
    push_s     = md_valid && md_ready && (md_reg != {ADDR_WIDTH{1'b0}});
    pop_s      = !pipe_hit_s && (count_s != {CW{1'b0}});
    push_req_s = '{rd: md_reg, data: md_data};
    if (pipe_hit_s) begin
      src_s = WB_PIPE;
    end else if (pop_s) begin
      src_s = WB_MD;
    end else begin
      src_s = WB_NONE;
    end
  end

  wb_fifo #(
    .T     (req_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock       (clock),
    .ctrl_resetn (ctrl_resetn),
    .push        (push_s),
    .push_data   (push_req_s),
    .pop         (pop_s),
    .head        (head_s),
    .count       (count_s)
  );

  // Ready is held low through reset and enabled one edge after release.
  always_ff @(posedge clock or negedge ctrl_resetn) begin
    if (!ctrl_resetn) begin
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
    end
  end

  // Registered regfile write port; reg/data hold when nothing is issued.
  always_ff @(posedge clock or negedge ctrl_resetn) begin
    if (!ctrl_resetn) begin
      we_r    <= 1'b0;
      wreg_r  <= {ADDR_WIDTH{1'b0}};
      wdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      case (src_s)
        WB_PIPE: begin
          we_r    <= 1'b1;
          wreg_r  <= pipe_reg;
          wdata_r <= pipe_data;
        end
        WB_MD: begin
          we_r    <= 1'b1;
          wreg_r  <= head_s.rd;
          wdata_r <= head_s.data;
        end
        WB_NONE: we_r <= 1'b0;
        default: we_r <= 1'b0;
      endcase
    end
  end

  assign md_ready         = ready_en_r && (count_s != FULL_C);
  assign fifo_count       = count_s;
  assign ctrl_writeEnable = we_r;
  assign ctrl_writeReg    = wreg_r;
  assign data_writeReg    = wdata_r;

`ifdef WB_SCOREBOARD_EN
  logic [31:0] busy_r;
  logic [31:0] set_s;
  logic [31:0] clr_s;

  // Set on issue, clear on the FIFO-sourced strobe edge; set wins a tie.
  always_comb begin
    if (md_issue) begin
      set_s = 32'd1 << md_issue_reg;
    end else begin
      set_s = 32'd0;
    end
    if (src_s == WB_MD) begin
      clr_s = 32'd1 << head_s.rd;
    end else begin
      clr_s = 32'd0;
    end
  end

  // Scoreboard state; bit 0 is forced clear.
  always_ff @(posedge clock or negedge ctrl_resetn) begin
    if (!ctrl_resetn) begin
      busy_r <= 32'd0;
    end else begin
      busy_r <= ((busy_r & ~clr_s) | set_s) & ~32'd1;
    end
  end

  assign busy = busy_r;
`endif

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed vector bench for writeback_arbiter; scoreboard checks compile in
// when WB_SCOREBOARD_EN is defined.
module tb_writeback_arbiter;

  logic        clock = 1'b0;
  logic        ctrl_resetn;
  logic        pipe_valid;
  logic [4:0]  pipe_reg;
  logic [31:0] pipe_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_reg;
  logic [31:0] md_data;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [1:0]  fifo_count;
`ifdef WB_SCOREBOARD_EN
  logic        md_issue;
  logic [4:0]  md_issue_reg;
  logic [31:0] busy;
`endif

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  writeback_arbiter dut (
    .clock            (clock),
    .ctrl_resetn      (ctrl_resetn),
    .pipe_valid       (pipe_valid),
    .pipe_reg         (pipe_reg),
    .pipe_data        (pipe_data),
    .md_valid         (md_valid),
    .md_ready         (md_ready),
    .md_reg           (md_reg),
    .md_data          (md_data),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .fifo_count       (fifo_count)
`ifdef WB_SCOREBOARD_EN
    ,
    .md_issue         (md_issue),
    .md_issue_reg     (md_issue_reg),
    .busy             (busy)
`endif
  );

  typedef struct {
    logic        pv;
    logic [4:0]  pr;
    logic [31:0] pd;
    logic        mv;
    logic [4:0]  mr;
    logic [31:0] md;
    logic        we;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [1:0]  cnt;
    logic        rdy;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  function automatic vec_t mk(logic pv, logic [4:0] pr, logic [31:0] pd,
                              logic mv, logic [4:0] mr, logic [31:0] md,
                              logic we, logic [4:0] wr, logic [31:0] wd,
                              logic [1:0] cnt, logic rdy);
    vec_t v;
    v.pv = pv; v.pr = pr; v.pd = pd; v.mv = mv; v.mr = mr; v.md = md;
    v.we = we; v.wr = wr; v.wd = wd; v.cnt = cnt; v.rdy = rdy;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(string tag, logic we, logic [4:0] wr, logic [31:0] wd,
                         logic [1:0] cnt, logic rdy);
    chk({tag, ".we"},    {31'd0, ctrl_writeEnable}, {31'd0, we});
    chk({tag, ".wreg"},  {27'd0, ctrl_writeReg},    {27'd0, wr});
    chk({tag, ".wdata"}, data_writeReg,             wd);
    chk({tag, ".count"}, {30'd0, fifo_count},       {30'd0, cnt});
    chk({tag, ".ready"}, {31'd0, md_ready},         {31'd0, rdy});
  endtask

  task automatic drive(logic pv, logic [4:0] pr, logic [31:0] pd,
                       logic mv, logic [4:0] mr, logic [31:0] md);
    pipe_valid = pv; pipe_reg = pr; pipe_data = pd;
    md_valid = mv; md_reg = mr; md_data = md;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // pipeline priority: FIFO fills to 2 while the pipeline writes r5
    tbl[0]  = mk(1'b1, 5'd5,  32'hA5A5A5A5, 1'b1, 5'd7,  32'h12345678, 1'b1, 5'd5,  32'hA5A5A5A5, 2'd1, 1'b1);
    tbl[1]  = mk(1'b1, 5'd5,  32'hA5A5A5A5, 1'b1, 5'd7,  32'h12345678, 1'b1, 5'd5,  32'hA5A5A5A5, 2'd2, 1'b0);
    tbl[2]  = mk(1'b1, 5'd5,  32'hA5A5A5A5, 1'b1, 5'd7,  32'h12345678, 1'b1, 5'd5,  32'hA5A5A5A5, 2'd2, 1'b0);
    tbl[3]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h12345678, 2'd1, 1'b1);
    tbl[4]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h12345678, 2'd0, 1'b1);
    tbl[5]  = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd7,  32'h12345678, 2'd0, 1'b1);
    // r0 suppression
    tbl[6]  = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h0000DEAD, 1'b0, 5'd7,  32'h12345678, 2'd1, 1'b1);
    tbl[7]  = mk(1'b1, 5'd0,  32'h0000FFFF, 1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  32'h0000DEAD, 2'd0, 1'b1);
    tbl[8]  = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h0000BEEF, 1'b0, 5'd9,  32'h0000DEAD, 2'd0, 1'b1);
    // ordering of same-register results
    tbl[9]  = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  32'd1,        1'b0, 5'd9,  32'h0000DEAD, 2'd1, 1'b1);
    tbl[10] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  32'd2,        1'b1, 5'd4,  32'd1,        2'd1, 1'b1);
    tbl[11] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  32'd2,        2'd0, 1'b1);
    // concurrent push/pop at occupancy 1
    tbl[12] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 32'h10,       1'b0, 5'd4,  32'd2,        2'd1, 1'b1);
    tbl[13] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd11, 32'h11,       1'b1, 5'd10, 32'h10,       2'd1, 1'b1);
    tbl[14] = mk(1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'h12,       1'b1, 5'd11, 32'h11,       2'd1, 1'b1);
    tbl[15] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'h12,       2'd0, 1'b1);
    tbl[16] = mk(1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd12, 32'h12,       2'd0, 1'b1);
    // r0 pipeline write with an empty FIFO, then a plain pipeline write
    tbl[17] = mk(1'b1, 5'd0,  32'h55,       1'b0, 5'd0,  32'h0,        1'b0, 5'd12, 32'h12,       2'd0, 1'b1);
    tbl[18] = mk(1'b1, 5'd31, 32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 32'hFFFFFFFF, 2'd0, 1'b1);

`ifdef WB_SCOREBOARD_EN
    md_issue = 1'b0;
    md_issue_reg = 5'd0;
`endif

    // reset held with a pipeline write pending
    ctrl_resetn = 1'b0;
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
    repeat (3) step();
    chk_all("reset", 1'b0, 5'd0, 32'h0, 2'd0, 1'b0);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    ctrl_resetn = 1'b1;
    step();
    chk_all("post_reset", 1'b0, 5'd0, 32'h0, 2'd0, 1'b1);

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].pv, tbl[i].pr, tbl[i].pd, tbl[i].mv, tbl[i].mr, tbl[i].md);
      step();
      chk_all($sformatf("vec%0d", i), tbl[i].we, tbl[i].wr, tbl[i].wd, tbl[i].cnt, tbl[i].rdy);
    end

`ifdef WB_SCOREBOARD_EN
    // busy[6] from issue edge to strobe edge; re-issue on the clear edge wins
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    md_issue = 1'b1; md_issue_reg = 5'd6;
    step();
    chk("sb.issue", {31'd0, busy[6]}, 32'd1);
    md_issue = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h66);
    step();
    chk("sb.queued", {31'd0, busy[6]}, 32'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    md_issue = 1'b1; md_issue_reg = 5'd6;
    step();
    chk("sb.reissue_we", {31'd0, ctrl_writeEnable}, 32'd1);
    chk("sb.reissue", {31'd0, busy[6]}, 32'd1);
    md_issue = 1'b1; md_issue_reg = 5'd0;
    drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd6, 32'h67);
    step();
    chk("sb.r0", busy, 32'h0000_0040);
    md_issue = 1'b0;
    drive(1'b1, 5'd6, 32'h99, 1'b0, 5'd0, 32'h0);
    step();
    chk("sb.pipe_no_clear", {31'd0, busy[6]}, 32'd1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    step();
    chk("sb.clear", busy, 32'h0);
    step();
`endif

    // reset mid-operation discards queued and in-flight writes
    drive(1'b1, 5'd2, 32'h22, 1'b1, 5'd8, 32'h88);
    step();
    chk_all("pre_midreset", 1'b1, 5'd2, 32'h22, 2'd1, 1'b1);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #2;
    ctrl_resetn = 1'b0;
    #1;
    chk_all("midreset", 1'b0, 5'd0, 32'h0, 2'd0, 1'b0);
    step();
    ctrl_resetn = 1'b1;
    step();
    chk_all("after_midreset", 1'b0, 5'd0, 32'h0, 2'd0, 1'b1);
    step();
    chk_all("after_midreset2", 1'b0, 5'd0, 32'h0, 2'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
